// File: rtl/f_devider_q_pkg.sv
// Shared types and constants for the f_devider_q programmable divider.
package f_devider_q_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [7:0] TERMINAL_CNT = 8'hFF;

  // Hex digit to segments {g,f,e,d,c,b,a}, active-high; entry 0 is the LSB slot.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/f_devider_q_counter4_slice.sv
// 4-bit loadable up-counter slice with count enable and carry-out.
module counter4_slice
  import f_devider_q_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    load_ni,
  input  logic    en_i,
  input  nibble_t d_i,
  output nibble_t q_o,
  output logic    co_o
);

  nibble_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!load_ni)  cnt_d = d_i;
    else if (en_i) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign q_o  = cnt_q;
  assign co_o = en_i & (cnt_q == 4'hF);

endmodule

// File: rtl/f_devider_q.sv
// 8-bit loadable up-counter / frequency divider with 7-segment low-nibble display.
// Optional AUTO_RELOAD_EN: reload the preset on terminal count instead of wrapping.
module f_devider_q
  import f_devider_q_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clock_oscillator,
  input  logic       pin_name1,
  input  logic       Load,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       A2,
  input  logic       B2,
  input  logic       C2,
  input  logic       D2,
  output logic       QA,
  output logic       QB,
  output logic       QC,
  output logic       QD,
  output logic       QA2,
  output logic       QB2,
  output logic       QC2,
  output logic       QD2,
  output logic [7:0] dis,
  output logic       maxmin
);

  nibble_t    lo_q, hi_q;
  logic       lo_co, hi_co;
  logic       load_n;
  logic [7:0] cnt;
  logic [6:0] seg;

  assign cnt    = {hi_q, lo_q};
  assign maxmin = (cnt == TERMINAL_CNT);

`ifdef AUTO_RELOAD_EN
  // Terminal count looks like a load cycle to both slices.
  assign load_n = Load & ~maxmin;
`else
  assign load_n = Load;
`endif

  counter4_slice u_lo (
    .clk_i   (clock_oscillator),
    .rst_ni  (pin_name1),
    .load_ni (load_n),
    .en_i    (1'b1),
    .d_i     ({D, C, B, A}),
    .q_o     (lo_q),
    .co_o    (lo_co)
  );

  counter4_slice u_hi (
    .clk_i   (clock_oscillator),
    .rst_ni  (pin_name1),
    .load_ni (load_n),
    .en_i    (lo_co),
    .d_i     ({D2, C2, B2, A2}),
    .q_o     (hi_q),
    .co_o    (hi_co)
  );

  always_comb begin
    seg = SEG_TABLE[lo_q];
    if (SEG_ACTIVE_LOW) seg = ~seg;
  end

  assign dis = {maxmin, seg};

  assign {QD, QC, QB, QA}     = lo_q;
  assign {QD2, QC2, QB2, QA2} = hi_q;

  logic unused_ok;
  assign unused_ok = hi_co;

endmodule

// File: tb/tb_f_devider_q.sv
// Directed, table-driven bench for f_devider_q (default SEG_ACTIVE_LOW = 0).
module tb_f_devider_q;

  logic clk = 1'b0;
  logic rst_n, load_n;
  logic [7:0] preset;
  logic QA, QB, QC, QD, QA2, QB2, QC2, QD2, maxmin;
  logic [7:0] dis;
  logic [7:0] q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  f_devider_q dut (
    .clock_oscillator(clk), .pin_name1(rst_n), .Load(load_n),
    .A(preset[0]), .B(preset[1]), .C(preset[2]), .D(preset[3]),
    .A2(preset[4]), .B2(preset[5]), .C2(preset[6]), .D2(preset[7]),
    .QA(QA), .QB(QB), .QC(QC), .QD(QD),
    .QA2(QA2), .QB2(QB2), .QC2(QC2), .QD2(QD2),
    .dis(dis), .maxmin(maxmin)
  );

  assign q = {QD2, QC2, QB2, QA2, QD, QC, QB, QA};

  typedef struct {
    logic       rst_n;
    logic       load_n;
    logic [7:0] preset;
    logic [7:0] exp_q;
    logic       exp_max;
    logic [7:0] exp_dis;
  } vec_t;

  vec_t tbl [10];

  task automatic step(input logic r, input logic l, input logic [7:0] p);
    rst_n = r; load_n = l; preset = p;
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [7:0] eq, input logic em, input logic [7:0] ed);
    n_vec++;
    if (q !== eq || maxmin !== em || dis !== ed) begin
      n_err++;
      $display("FAIL %s: got q=%02h max=%b dis=%02h, want q=%02h max=%b dis=%02h",
               name, q, maxmin, dis, eq, em, ed);
    end
  endtask

  task automatic check_q(input string name, input logic [7:0] eq);
    n_vec++;
    if (q !== eq) begin
      n_err++;
      $display("FAIL %s: got q=%02h, want q=%02h", name, q, eq);
    end
  endtask

  initial begin
    int cyc;
    logic [7:0] exp;

    tbl[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h3F};  // reset
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h3F};
    tbl[2] = '{1'b1, 1'b0, 8'h8F, 8'h8F, 1'b0, 8'h71};  // load 8F
    tbl[3] = '{1'b1, 1'b1, 8'h00, 8'h90, 1'b0, 8'h3F};  // carry into high slice
    tbl[4] = '{1'b0, 1'b0, 8'hAA, 8'h00, 1'b0, 8'h3F};  // reset beats load
    tbl[5] = '{1'b1, 1'b0, 8'hAA, 8'hAA, 1'b0, 8'h77};
    tbl[6] = '{1'b1, 1'b0, 8'hAA, 8'hAA, 1'b0, 8'h77};  // load held: frozen
    tbl[7] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hF1};  // preset FF -> maxmin now
`ifdef AUTO_RELOAD_EN
    tbl[8] = '{1'b1, 1'b1, 8'h12, 8'h12, 1'b0, 8'h5B};
    tbl[9] = '{1'b1, 1'b1, 8'h12, 8'h13, 1'b0, 8'h4F};
`else
    tbl[8] = '{1'b1, 1'b1, 8'h12, 8'h00, 1'b0, 8'h3F};  // wrap
    tbl[9] = '{1'b1, 1'b1, 8'h12, 8'h01, 1'b0, 8'h06};
`endif

    rst_n = 1'b0; load_n = 1'b1; preset = 8'h00;
    #2;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst_n, tbl[i].load_n, tbl[i].preset);
      check($sformatf("vec%0d", i), tbl[i].exp_q, tbl[i].exp_max, tbl[i].exp_dis);
    end

    // Count 0x8F -> 0xFF in 112 clocks; preset changes are ignored while counting.
    step(1'b1, 1'b0, 8'h8F);
    check_q("load8F", 8'h8F);
    exp = 8'h8F;
    for (int i = 0; i < 112; i++) begin
      step(1'b1, 1'b1, 8'(i * 7));
      exp = exp + 8'd1;
      if (q !== exp) check_q($sformatf("count%0d", i), exp);
    end
    check("term", 8'hFF, 1'b1, 8'hF1);
    step(1'b1, 1'b1, 8'h8F);
`ifdef AUTO_RELOAD_EN
    check("after_term", 8'h8F, 1'b0, 8'h71);
`else
    check("after_term", 8'h00, 1'b0, 8'h3F);
`endif

    // External reload loop: pulse Load on each maxmin.
    step(1'b1, 1'b0, 8'h8F);
    for (int p = 0; p < 3; p++) begin
      cyc = 0;
      while (!maxmin && cyc < 300) begin
        step(1'b1, 1'b1, 8'h8F);
        cyc++;
      end
      n_vec++;
      if (cyc != 112) begin
        n_err++;
        $display("FAIL period%0d: got %0d cycles to maxmin, want 112", p, cyc);
      end
      step(1'b1, 1'b0, 8'h8F);
      check($sformatf("reload%0d", p), 8'h8F, 1'b0, 8'h71);
    end

    // Reset mid-count.
    step(1'b1, 1'b0, 8'h50);
    repeat (12) step(1'b1, 1'b1, 8'h00);
    check("at5C", 8'h5C, 1'b0, 8'h39);
    step(1'b0, 1'b1, 8'h00);
    check("mid_reset", 8'h00, 1'b0, 8'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
